// File: rtl/bram_arb_pkg.sv
// Shared definitions for the two-master blockram port arbiter: FSM encodings,
// master indices and the data word returned on a watchdog-generated ack.
package bram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        GNT0    = 2'b01,
        GNT1    = 2'b10,
        RELEASE = 2'b11
    } arb_state_t;

    localparam logic        M_ADC        = 1'b0;
    localparam logic        M_HOST       = 1'b1;
    localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_DEAD;

endpackage

// File: rtl/bram_arb_fsm.sv
// Grant FSM with round-robin pointer; grant registered one cycle after cyc,
// held until the owner drops cyc, then one RELEASE dead cycle before IDLE.
module bram_arb_fsm
    import bram_arb_pkg::*;
#(
    parameter int PRIO_M0 = 0
) (
    input  logic       wb_clk_i,
    input  logic       reset,
    input  logic       m0_cyc_i,
    input  logic       m1_cyc_i,
    output arb_state_t state,
    output logic [1:0] grant
);

    logic last;

    // m0 wins when alone, under fixed priority, or when m1 was served last.
    logic pick_m0;
    assign pick_m0 = m0_cyc_i && (!m1_cyc_i || (PRIO_M0 != 0) || (last == M_HOST));

    always_ff @(posedge wb_clk_i) begin
        if (reset) begin
            state <= IDLE;
            grant <= 2'b00;
            last  <= M_HOST;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_m0) begin
                        state <= GNT0;
                        grant <= 2'b01;
                        last  <= M_ADC;
                    end else if (m1_cyc_i) begin
                        state <= GNT1;
                        grant <= 2'b10;
                        last  <= M_HOST;
                    end
                end
                GNT0: begin
                    if (!m0_cyc_i) begin
                        state <= RELEASE;
                        grant <= 2'b00;
                    end
                end
                GNT1: begin
                    if (!m1_cyc_i) begin
                        state <= RELEASE;
                        grant <= 2'b00;
                    end
                end
                RELEASE: begin
                    state <= IDLE;
                    grant <= 2'b00;
                end
                default: begin
                    state <= IDLE;
                    grant <= 2'b00;
                end
            endcase
        end
    end

endmodule

// File: rtl/bram_port_arbiter.sv
// Two-master Wishbone arbiter for the blockram port; slave sees cyc 1 cycle after request, waiting master gets ack=0.
// ARB_TIMEOUT_EN adds a watchdog that synthesises an ack plus sticky timeout_o when the slave stalls.
module bram_port_arbiter
    import bram_arb_pkg::*;
#(
    parameter int PRIO_M0        = 0,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int AW             = 32
) (
    input  logic          wb_clk_i,
    input  logic          reset,
    input  logic          m0_cyc_i,
    input  logic          m0_stb_i,
    input  logic          m0_we_i,
    input  logic [3:0]    m0_sel_i,
    input  logic [AW-1:0] m0_adr_i,
    input  logic [31:0]   m0_dat_i,
    output logic [31:0]   m0_dat_o,
    output logic          m0_ack_o,
    input  logic          m1_cyc_i,
    input  logic          m1_stb_i,
    input  logic          m1_we_i,
    input  logic [3:0]    m1_sel_i,
    input  logic [AW-1:0] m1_adr_i,
    input  logic [31:0]   m1_dat_i,
    output logic [31:0]   m1_dat_o,
    output logic          m1_ack_o,
    output logic          s_cyc_o,
    output logic          s_stb_o,
    output logic          s_we_o,
    output logic [3:0]    s_sel_o,
    output logic [AW-1:0] s_adr_o,
    output logic [31:0]   s_dat_o,
    input  logic [31:0]   s_dat_i,
    input  logic          s_ack_i,
    output logic [1:0]    grant_o,
    output logic [1:0]    state_o
`ifdef ARB_TIMEOUT_EN
    ,
    output logic          timeout_o
`endif
);

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be within 1..255");
    end

    arb_state_t state;
    logic       granted;
    logic       owner_stb;
    logic       wd_fire;

    bram_arb_fsm #(
        .PRIO_M0 (PRIO_M0)
    ) u_fsm (
        .wb_clk_i (wb_clk_i),
        .reset    (reset),
        .m0_cyc_i (m0_cyc_i),
        .m1_cyc_i (m1_cyc_i),
        .state    (state),
        .grant    (grant_o)
    );

    assign state_o   = state;
    assign granted   = (state == GNT0) || (state == GNT1);
    assign owner_stb = (state == GNT0) ? m0_stb_i :
                       (state == GNT1) ? m1_stb_i : 1'b0;

    // Slave side: owner's signals pass straight through, everything else is quiet.
    always_comb begin
        s_cyc_o = 1'b0;
        s_stb_o = 1'b0;
        s_we_o  = 1'b0;
        s_sel_o = '0;
        s_adr_o = '0;
        s_dat_o = '0;
        case (state)
            GNT0: begin
                s_cyc_o = m0_cyc_i;
                s_stb_o = m0_stb_i;
                s_we_o  = m0_we_i;
                s_sel_o = m0_sel_i;
                s_adr_o = m0_adr_i;
                s_dat_o = m0_dat_i;
            end
            GNT1: begin
                s_cyc_o = m1_cyc_i;
                s_stb_o = m1_stb_i;
                s_we_o  = m1_we_i;
                s_sel_o = m1_sel_i;
                s_adr_o = m1_adr_i;
                s_dat_o = m1_dat_i;
            end
            default: ;
        endcase
    end

    always_comb begin
        m0_ack_o = 1'b0;
        m0_dat_o = '0;
        m1_ack_o = 1'b0;
        m1_dat_o = '0;
        case (state)
            GNT0: begin
                m0_ack_o = s_ack_i | wd_fire;
                m0_dat_o = wd_fire ? TIMEOUT_DATA : s_dat_i;
            end
            GNT1: begin
                m1_ack_o = s_ack_i | wd_fire;
                m1_dat_o = wd_fire ? TIMEOUT_DATA : s_dat_i;
            end
            default: ;
        endcase
    end

`ifdef ARB_TIMEOUT_EN
    localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT_CYCLES);

    logic [7:0] wd_cnt;
    logic       timeout_q;

    assign wd_fire   = granted && owner_stb && !s_ack_i && (wd_cnt == TO_LIMIT);
    assign timeout_o = timeout_q;

    // Counter restarts with every grant (it is held at zero outside one) and every real ack.
    always_ff @(posedge wb_clk_i) begin
        if (reset) begin
            wd_cnt    <= 8'd0;
            timeout_q <= 1'b0;
        end else begin
            if (!granted || s_ack_i || wd_fire) begin
                wd_cnt <= 8'd0;
            end else if (owner_stb) begin
                wd_cnt <= wd_cnt + 8'd1;
            end
            if (wd_fire) begin
                timeout_q <= 1'b1;
            end
        end
    end
`else
    logic unused_wd;
    assign unused_wd = granted & owner_stb;
    assign wd_fire   = 1'b0;
`endif

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Directed bench for bram_port_arbiter: a round-robin instance and a fixed-priority instance share the stimulus.
module tb_bram_port_arbiter;

    logic        wb_clk_i = 1'b0;
    logic        reset    = 1'b1;
    logic        m0_cyc = 1'b0, m0_stb = 1'b0, m0_we = 1'b0;
    logic [3:0]  m0_sel = '0;
    logic [31:0] m0_adr = '0, m0_dat = '0;
    logic        m1_cyc = 1'b0, m1_stb = 1'b0, m1_we = 1'b0;
    logic [3:0]  m1_sel = '0;
    logic [31:0] m1_adr = '0, m1_dat = '0;
    logic [31:0] s_dat_i = '0;
    logic        s_ack_i = 1'b0;

    logic [31:0] rr_m0_dat, rr_m1_dat, rr_s_adr, rr_s_dat;
    logic        rr_m0_ack, rr_m1_ack, rr_s_cyc, rr_s_stb, rr_s_we;
    logic [3:0]  rr_s_sel;
    logic [1:0]  rr_grant, rr_state;
    logic [31:0] pr_m0_dat, pr_m1_dat, pr_s_adr, pr_s_dat;
    logic        pr_m0_ack, pr_m1_ack, pr_s_cyc, pr_s_stb, pr_s_we;
    logic [3:0]  pr_s_sel;
    logic [1:0]  pr_grant, pr_state;
`ifdef ARB_TIMEOUT_EN
    logic        rr_timeout, pr_timeout;
`endif

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 wb_clk_i = ~wb_clk_i;

    bram_port_arbiter #(.PRIO_M0(0), .TIMEOUT_CYCLES(8), .AW(32)) dut_rr (
        .wb_clk_i(wb_clk_i), .reset(reset),
        .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_sel_i(m0_sel),
        .m0_adr_i(m0_adr), .m0_dat_i(m0_dat), .m0_dat_o(rr_m0_dat), .m0_ack_o(rr_m0_ack),
        .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_sel_i(m1_sel),
        .m1_adr_i(m1_adr), .m1_dat_i(m1_dat), .m1_dat_o(rr_m1_dat), .m1_ack_o(rr_m1_ack),
        .s_cyc_o(rr_s_cyc), .s_stb_o(rr_s_stb), .s_we_o(rr_s_we), .s_sel_o(rr_s_sel),
        .s_adr_o(rr_s_adr), .s_dat_o(rr_s_dat), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i),
        .grant_o(rr_grant), .state_o(rr_state)
`ifdef ARB_TIMEOUT_EN
        , .timeout_o(rr_timeout)
`endif
    );

    bram_port_arbiter #(.PRIO_M0(1), .TIMEOUT_CYCLES(8), .AW(32)) dut_pr (
        .wb_clk_i(wb_clk_i), .reset(reset),
        .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_sel_i(m0_sel),
        .m0_adr_i(m0_adr), .m0_dat_i(m0_dat), .m0_dat_o(pr_m0_dat), .m0_ack_o(pr_m0_ack),
        .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_sel_i(m1_sel),
        .m1_adr_i(m1_adr), .m1_dat_i(m1_dat), .m1_dat_o(pr_m1_dat), .m1_ack_o(pr_m1_ack),
        .s_cyc_o(pr_s_cyc), .s_stb_o(pr_s_stb), .s_we_o(pr_s_we), .s_sel_o(pr_s_sel),
        .s_adr_o(pr_s_adr), .s_dat_o(pr_s_dat), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i),
        .grant_o(pr_grant), .state_o(pr_state)
`ifdef ARB_TIMEOUT_EN
        , .timeout_o(pr_timeout)
`endif
    );

    task automatic step();
        @(posedge wb_clk_i);
        #2;
    endtask

    task automatic idle_masters();
        m0_cyc = 1'b0; m0_stb = 1'b0; m0_we = 1'b0;
        m1_cyc = 1'b0; m1_stb = 1'b0; m1_we = 1'b0;
        s_ack_i = 1'b0; s_dat_i = '0;
    endtask

    task automatic do_reset();
        idle_masters();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        m0_cyc = 1'b1; m0_stb = 1'b1; m0_adr = 32'h44;
        s_ack_i = 1'b1; s_dat_i = 32'h1234_5678;
        step();
        step();
        total_cnt++;
        if ({rr_state, rr_grant} !== 4'b0000) $display("FAIL reset_state: state/grant got %b want 0000", {rr_state, rr_grant});
        else pass_cnt++;
        total_cnt++;
        if ({rr_s_cyc, rr_s_stb, rr_s_adr} !== 34'd0) $display("FAIL reset_slave: cyc/stb/adr got %h want 0", {rr_s_cyc, rr_s_stb, rr_s_adr});
        else pass_cnt++;
        total_cnt++;
        if ({rr_m0_ack, rr_m0_dat} !== 33'd0) $display("FAIL reset_m0: ack/dat got %h want 0", {rr_m0_ack, rr_m0_dat});
        else pass_cnt++;
        reset = 1'b0;
        idle_masters();
        step();
    endtask

    task automatic test_single_write();
        do_reset();
        m0_cyc = 1'b1; m0_stb = 1'b1; m0_we = 1'b1;
        m0_sel = 4'hF; m0_adr = 32'h10; m0_dat = 32'hABCD_EF01;
        #1;
        total_cnt++;
        if ({rr_grant, rr_s_cyc} !== 3'b000) $display("FAIL sw_not_yet: grant/s_cyc got %b want 000", {rr_grant, rr_s_cyc});
        else pass_cnt++;
        step();
        total_cnt++;
        if (rr_grant !== 2'b01) $display("FAIL sw_grant: got %b want 01", rr_grant);
        else pass_cnt++;
        total_cnt++;
        if ({rr_s_cyc, rr_s_we, rr_s_sel, rr_s_adr, rr_s_dat} !== {1'b1, 1'b1, 4'hF, 32'h10, 32'hABCD_EF01})
            $display("FAIL sw_slave: got %h want %h", {rr_s_cyc, rr_s_we, rr_s_sel, rr_s_adr, rr_s_dat},
                     {1'b1, 1'b1, 4'hF, 32'h10, 32'hABCD_EF01});
        else pass_cnt++;
        s_ack_i = 1'b1;
        #1;
        total_cnt++;
        if ({rr_m0_ack, rr_m1_ack} !== 2'b10) $display("FAIL sw_ack_route: m0/m1 ack got %b want 10", {rr_m0_ack, rr_m1_ack});
        else pass_cnt++;
        step();
        idle_masters();
        step();
        total_cnt++;
        if ({rr_state, rr_s_cyc} !== 3'b110) $display("FAIL sw_release: state/s_cyc got %b want 110", {rr_state, rr_s_cyc});
        else pass_cnt++;
        step();
        total_cnt++;
        if (rr_state !== 2'b00) $display("FAIL sw_idle: state got %b want 00", rr_state);
        else pass_cnt++;
    endtask

    task automatic test_round_robin();
        do_reset();
        m0_cyc = 1'b1; m0_stb = 1'b1; m0_adr = 32'h20;
        m1_cyc = 1'b1; m1_stb = 1'b1; m1_adr = 32'h30;
        step();
        total_cnt++;
        if (rr_grant !== 2'b01) $display("FAIL rr_first_tie: grant got %b want 01", rr_grant);
        else pass_cnt++;
        s_ack_i = 1'b1; s_dat_i = 32'h5555_AAAA;
        #1;
        total_cnt++;
        if ({rr_m1_ack, rr_m1_dat} !== 33'd0) $display("FAIL rr_waiter_quiet: m1 ack/dat got %h want 0", {rr_m1_ack, rr_m1_dat});
        else pass_cnt++;
        step();
        m0_cyc = 1'b0; m0_stb = 1'b0; s_ack_i = 1'b0;
        step();
        step();
        total_cnt++;
        if (rr_grant !== 2'b00) $display("FAIL rr_turnaround: grant got %b want 00", rr_grant);
        else pass_cnt++;
        step();
        total_cnt++;
        if ({rr_grant, rr_s_adr} !== {2'b10, 32'h30}) $display("FAIL rr_m1_grant: grant/adr got %h want %h", {rr_grant, rr_s_adr}, {2'b10, 32'h30});
        else pass_cnt++;
        idle_masters();
        step();
        step();
        // m0 served alone moves the pointer to m0, so the next tie goes to m1.
        m0_cyc = 1'b1; m0_stb = 1'b1;
        step();
        m0_cyc = 1'b0; m0_stb = 1'b0;
        step();
        step();
        m0_cyc = 1'b1; m0_stb = 1'b1; m1_cyc = 1'b1; m1_stb = 1'b1;
        step();
        total_cnt++;
        if (rr_grant !== 2'b10) $display("FAIL rr_second_tie: grant got %b want 10", rr_grant);
        else pass_cnt++;
        idle_masters();
        step();
        step();
    endtask

    task automatic test_priority();
        logic m0_seen;
        do_reset();
        m0_seen = 1'b0;
        m1_cyc = 1'b1; m1_stb = 1'b1;
        s_ack_i = 1'b1; s_dat_i = 32'hCAFE_F00D;
        for (int c = 0; c < 15; c++) begin
            m0_cyc = (c % 3) != 2;
            m0_stb = m0_cyc;
            step();
            if (pr_grant == 2'b01) m0_seen = 1'b1;
            total_cnt++;
            if ({pr_grant[1], pr_m1_ack, pr_m1_dat} !== 34'd0)
                $display("FAIL prio_starve c=%0d: grant1/ack/dat got %h want 0", c, {pr_grant[1], pr_m1_ack, pr_m1_dat});
            else pass_cnt++;
        end
        total_cnt++;
        if (m0_seen !== 1'b1) $display("FAIL prio_m0_served: seen got %b want 1", m0_seen);
        else pass_cnt++;
        idle_masters();
        step();
        step();
    endtask

    task automatic test_burst();
        do_reset();
        m1_cyc = 1'b1; m1_stb = 1'b1; m1_we = 1'b0; m1_adr = 32'h0;
        step();
        m0_cyc = 1'b1; m0_stb = 1'b1;
        for (int i = 0; i < 4; i++) begin
            m1_adr  = 32'(i * 4);
            s_dat_i = 32'h1111 * 32'(i + 1);
            s_ack_i = 1'b1;
            #1;
            total_cnt++;
            if ({rr_grant, rr_s_adr, rr_m1_dat, rr_m1_ack, rr_m0_ack} !== {2'b10, 32'(i * 4), 32'h1111 * 32'(i + 1), 1'b1, 1'b0})
                $display("FAIL burst_beat%0d: grant/adr/dat/ack got %h want %h", i,
                         {rr_grant, rr_s_adr, rr_m1_dat, rr_m1_ack, rr_m0_ack},
                         {2'b10, 32'(i * 4), 32'h1111 * 32'(i + 1), 1'b1, 1'b0});
            else pass_cnt++;
            step();
        end
        m1_cyc = 1'b0; m1_stb = 1'b0; s_ack_i = 1'b0;
        step();
        total_cnt++;
        if ({rr_state, rr_grant} !== 4'b1100) $display("FAIL burst_release: state/grant got %b want 1100", {rr_state, rr_grant});
        else pass_cnt++;
        step();
        step();
        total_cnt++;
        if (rr_grant !== 2'b01) $display("FAIL burst_m0_after: grant got %b want 01", rr_grant);
        else pass_cnt++;
        idle_masters();
        step();
        step();
    endtask

    task automatic test_reset_mid();
        do_reset();
        m0_cyc = 1'b1; m0_stb = 1'b1; m0_adr = 32'h80;
        step();
        total_cnt++;
        if (rr_s_cyc !== 1'b1) $display("FAIL rmid_active: s_cyc got %b want 1", rr_s_cyc);
        else pass_cnt++;
        reset = 1'b1;
        step();
        s_ack_i = 1'b1; s_dat_i = 32'h7777_7777;
        #1;
        total_cnt++;
        if ({rr_s_cyc, rr_grant, rr_state, rr_m0_ack} !== 6'd0)
            $display("FAIL rmid_abandon: cyc/grant/state/ack got %b want 000000", {rr_s_cyc, rr_grant, rr_state, rr_m0_ack});
        else pass_cnt++;
        reset = 1'b0;
        idle_masters();
        step();
    endtask

`ifdef ARB_TIMEOUT_EN
    task automatic test_timeout();
        int ack_at;
        do_reset();
        m0_cyc = 1'b1; m0_stb = 1'b1;
        step();
        ack_at = -1;
        for (int k = 0; k < 20 && ack_at < 0; k++) begin
            if (rr_m0_ack === 1'b1) begin
                ack_at = k;
                total_cnt++;
                if (rr_m0_dat !== 32'hDEAD_DEAD) $display("FAIL to_data: got %h want deaddead", rr_m0_dat);
                else pass_cnt++;
            end else begin
                step();
            end
        end
        total_cnt++;
        if (ack_at !== 8) $display("FAIL to_latency: ack after %0d cycles want 8", ack_at);
        else pass_cnt++;
        idle_masters();
        step();
        step();
        step();
        total_cnt++;
        if ({rr_timeout, rr_m0_ack} !== 2'b10) $display("FAIL to_sticky: timeout/ack got %b want 10", {rr_timeout, rr_m0_ack});
        else pass_cnt++;
        do_reset();
        total_cnt++;
        if (rr_timeout !== 1'b0) $display("FAIL to_reset_clear: got %b want 0", rr_timeout);
        else pass_cnt++;
    endtask
`endif

    initial begin
        test_reset();
        test_single_write();
        test_round_robin();
        test_priority();
        test_burst();
        test_reset_mid();
`ifdef ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
